vec_operand_fetch: RTL

//  Upstream stage of the 8-lane vector ALU. On a start pulse, fetches LANES words for operand A
//  and LANES words for operand B, one word at a time, over a scalar memory read port.

---
 rtl/vec_operand_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/vec_operand_fetch.sv
// Fetches LANES A words then LANES B words over a one-outstanding scalar read port, then holds them for the ALU.
// Zero-wait latency is 2*LANES+1 cycles from start; each memory wait adds one, and ops_ready low holds the set in PRESENT.
module vec_operand_fetch #(
  parameter int N      = 32,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_a,
  input  logic [ADDR_W-1:0]    base_b,
  input  logic [1:0]           op_in,
  output logic                 busy,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [N-1:0]         mem_rdata,
  input  logic                 mem_rvalid,
  output logic [N*LANES-1:0]   opa_flat,
  output logic [N*LANES-1:0]   opb_flat,
  output logic [1:0]           selec_out,
  output logic                 ops_valid,
  input  logic                 ops_ready
);

  localparam int              CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  base_a_q;
  logic [ADDR_W-1:0]  base_b_q;
  logic               beat;
  logic               accept;
  logic [ADDR_W-1:0]  next_addr;

  assign busy   = (state != IDLE);
  assign beat   = mem_req && mem_rvalid;
  // A new start is taken from IDLE, or in the same cycle the presented set is consumed.
  assign accept = start && ((state == IDLE) ||
                            ((state == PRESENT) && ops_valid && ops_ready));

  // Address of the following beat; the add wraps naturally at ADDR_W bits.
  assign next_addr = ((state == FETCH_A) ? base_a_q : base_b_q)
                   + ADDR_W'(cnt) + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      opa_flat  <= '0;
      opb_flat  <= '0;
      selec_out <= 2'b00;
      ops_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        FETCH_A: begin
          if (beat) begin
            opa_flat[int'(cnt)*N +: N] <= mem_rdata;
            if (cnt == LAST) begin
              cnt      <= '0;
              state    <= FETCH_B;
              mem_addr <= base_b_q;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= next_addr;
            end
          end
        end
        FETCH_B: begin
          if (beat) begin
            opb_flat[int'(cnt)*N +: N] <= mem_rdata;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= PRESENT;
              mem_req   <= 1'b0;
              ops_valid <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= next_addr;
            end
          end
        end
        PRESENT: begin
          if (ops_ready) begin
            ops_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the case so an accepted start overrides the PRESENT->IDLE move.
      if (accept) begin
        base_a_q  <= base_a;
        base_b_q  <= base_b;
        selec_out <= op_in;
        cnt       <= '0;
        state     <= FETCH_A;
        mem_req   <= 1'b1;
        mem_addr  <= base_a;
      end
    end
  end

endmodule
